riscv_alu: RTL and testbench
============================

# riscv_alu

Registered 32-bit integer ALU for the RV32I execute stage. It computes one of ten RISC-V arithmetic, logic, shift or compare operations on two 32-bit operands. The block presents the result and a zero flag one clock cycle later, qualified by a valid bit. The branch unit uses the zero flag for BEQ/BNE decisions.

## Interface
Parameters:
- none. Widths are fixed at 32 bits. The operation type `alu_op_t` comes from `riscv_pkg`.

Ports:
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `in_valid` input 1: when high, the operands and opcode are valid this cycle.
- `a` input 32: operand A (rs1 / PC).
- `b` input 32: operand B (rs2 / immediate).
- `alu_op` input `alu_op_t` (4 bits): operation select.
- `result` output 32: registered result.
- `zero` output 1: registered flag, high when `result == 0`.
- `out_valid` output 1: `result` and `zero` are valid this cycle.

`alu_op_t` encoding (4 bits):
- ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_XOR=4
- ALU_SLL=5, ALU_SRL=6, ALU_SRA=7, ALU_SLT=8, ALU_SLTU=9
- codes 10–15 are reserved.

## Operation
- ADD: a + b, modulo 2^32; no carry or overflow output.
- SUB: a − b, modulo 2^32.
- AND, OR, XOR: bitwise.
- SLL: a << b[4:0]. Bits b[31:5] are ignored.
- SRL: a >> b[4:0], logical (zero fill).
- SRA: a >>> b[4:0], arithmetic (a[31] replicated).
- SLT: 1 if $signed(a) < $signed(b), else 0. The result is zero-extended to 32 bits.
- SLTU: 1 if a < b unsigned, else 0. The result is zero-extended.
- Reserved opcodes: the next-result value is 32'h0, so `zero`=1.
- Next-state logic is combinational. When `in_valid`=1, the computed result is captured into `result`, and `zero` is set to (computed result == 0).
- When `in_valid`=0, `result` and `zero` hold their previous values.
- `out_valid` is `in_valid` delayed by one cycle.

## Timing
- Latency is one cycle. Inputs sampled at rising edge N appear on the outputs after edge N; they are valid in cycle N+1 with `out_valid`=1.
- Throughput is one operation per cycle. There is no backpressure and no stall input.
- Reset: while `rst_n`=0 at a rising edge, the registers take `result`=0, `zero`=1, `out_valid`=0.
- Reset overrides `in_valid`. An operation presented in the same cycle as reset is discarded.
- Reset has no asynchronous effect. The outputs change only at a clock edge.
- After `rst_n` rises, the first `in_valid` operation appears one cycle later.
- Back-to-back operations each produce an independent result in consecutive cycles.
- `zero` is always consistent with the registered `result`, in the same cycle.

## Test plan
- Reset, then a=10, b=20, in_valid=1, cycling through all ops one per cycle. Required outputs on consecutive cycles:
  - ADD→30, SUB→32'hFFFFFFF6, AND→0 (zero=1), OR→30, XOR→30
  - SLL→32'h00A00000, SRL→0 (zero=1), SRA→0 (zero=1), SLT→1, SLTU→1
- Signed vs unsigned compare, a=32'hFFFFFFFF, b=1:
  - SLT→1, SLTU→0 (zero=1)
  - SRA with b=4→32'hFFFFFFFF
  - SRL with b=4→32'h0FFFFFFF
- Shift masking, a=1, b=32'h00000021: SLL→2. Only b[4:0]=1 is used.
- Wrap-around:
  - a=32'hFFFFFFFF, b=1, ADD→0 with zero=1.
  - a=0, b=1, SUB→32'hFFFFFFFF with zero=0.
- Hold and valid:
  - After ADD 5+5=10, drop in_valid for 3 cycles. Required: result stays 10, out_valid=0 for those cycles.
  - Reserved opcode 12 with in_valid=1 → result 0, zero=1.
- Reset mid-stream: assert rst_n=0 during a valid ADD. Required: the next cycle shows result=0, zero=1, out_valid=0, and that ADD result never appears.

Source files
------------

// File: rtl/riscv_alu.sv
// riscv_alu: registered RV32I integer ALU with result, zero flag and valid, one-cycle latency
package riscv_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;
endpackage

module riscv_alu
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_t     alu_op,
    output logic [31:0] result,
    output logic        zero,
    output logic        out_valid
);
    logic [31:0] res;
    logic [31:0] result_d, result_q;
    logic        zero_d, zero_q;
    logic        out_valid_d, out_valid_q;
    logic [4:0]  shamt;

    assign shamt = b[4:0];

    always_comb begin
        res = '0;
        case (alu_op)
            ALU_ADD:  res = a + b;
            ALU_SUB:  res = a - b;
            ALU_AND:  res = a & b;
            ALU_OR:   res = a | b;
            ALU_XOR:  res = a ^ b;
            ALU_SLL:  res = a << shamt;
            ALU_SRL:  res = a >> shamt;
            ALU_SRA:  res = $signed(a) >>> shamt;
            ALU_SLT:  res = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: res = {31'b0, a < b};
            default:  res = '0;
        endcase
        result_d    = in_valid ? res : result_q;
        zero_d      = in_valid ? (res == '0) : zero_q;
        out_valid_d = in_valid;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q    <= '0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign result    = result_q;
    assign zero      = zero_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_riscv_alu.sv
// tb_riscv_alu: scoreboard bench for riscv_alu with directed and randomized operations
module tb_riscv_alu;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    alu_op_t     alu_op = ALU_ADD;
    logic [31:0] result;
    logic        zero;
    logic        out_valid;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    riscv_alu dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .alu_op(alu_op), .result(result), .zero(zero), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(logic [31:0] x, logic [31:0] y, int op);
        int s = int'(y % 32);
        logic [31:0] r = '0;
        case (op)
            0: r = x + y;
            1: r = x - y;
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5, 6, 7:
                for (int i = 0; i < 32; i++) begin
                    int j = (op == 5) ? i - s : i + s;
                    r[i] = (j < 0) ? 1'b0 : (j > 31) ? ((op == 7) ? x[31] : 1'b0) : x[j];
                end
            8: r = (longint'($signed(x)) < longint'($signed(y))) ? 32'd1 : 32'd0;
            9: r = (longint'(x) < longint'(y)) ? 32'd1 : 32'd0;
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic issue_x(logic [31:0] x, logic [31:0] y, int op, logic [31:0] req);
        a = x;
        b = y;
        alu_op = alu_op_t'(op[3:0]);
        in_valid = 1'b1;
        if (rst_n) exp_q.push_back(req);
        @(posedge clk);
        #1;
    endtask

    task automatic issue(logic [31:0] x, logic [31:0] y, int op);
        issue_x(x, y, op, model(x, y, op));
    endtask

    task automatic idle(int n);
        in_valid = 1'b0;
        repeat (n) begin
            a = $urandom;
            b = $urandom;
            alu_op = alu_op_t'($urandom_range(0, 15));
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: pops on out_valid, otherwise checks that outputs hold
    initial begin
        logic rs;
        logic [31:0] held = '0;
        logic [31:0] e;
        forever begin
            @(posedge clk);
            rs = rst_n;
            #1;
            if (!rs) begin
                held = '0;
                chk("rst_valid", {31'b0, out_valid}, 32'd0);
                chk("rst_result", result, 32'd0);
                chk("rst_zero", {31'b0, zero}, 32'd1);
            end else if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", {31'b0, out_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    held = e;
                    chk("result", result, e);
                    chk("zero", {31'b0, zero}, {31'b0, e == '0});
                end
            end else begin
                chk("hold_result", result, held);
                chk("hold_zero", {31'b0, zero}, {31'b0, held == '0});
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue_x(10, 20, 0, 32'd30);
        issue_x(10, 20, 1, 32'hFFFFFFF6);
        issue_x(10, 20, 2, 32'd0);
        issue_x(10, 20, 3, 32'd30);
        issue_x(10, 20, 4, 32'd30);
        issue_x(10, 20, 5, 32'h00A00000);
        issue_x(10, 20, 6, 32'd0);
        issue_x(10, 20, 7, 32'd0);
        issue_x(10, 20, 8, 32'd1);
        issue_x(10, 20, 9, 32'd1);
        issue_x(32'hFFFFFFFF, 1, 8, 32'd1);
        issue_x(32'hFFFFFFFF, 1, 9, 32'd0);
        issue_x(32'hFFFFFFFF, 4, 7, 32'hFFFFFFFF);
        issue_x(32'hFFFFFFFF, 4, 6, 32'h0FFFFFFF);
        issue_x(1, 32'h21, 5, 32'd2);
        issue_x(32'hFFFFFFFF, 1, 0, 32'd0);
        issue_x(0, 1, 1, 32'hFFFFFFFF);
        issue_x(5, 5, 0, 32'd10);
        idle(3);
        issue_x(32'h1234, 32'h5678, 12, 32'd0);
        issue_x(7, 9, 0, 32'd16);
        rst_n = 1'b0;
        issue_x(3, 4, 0, 32'd7);
        rst_n = 1'b1;
        idle(2);
        repeat (400) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            else issue($urandom, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom,
                       $urandom_range(0, 15));
        end
        issue(32'h80000000, 31, 7);
        issue(32'h80000000, 31, 6);
        issue(32'h7FFFFFFF, 32'h80000000, 8);
        issue(32'h7FFFFFFF, 32'h80000000, 9);
        idle(3);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
